// File: rtl/fifo_pump_if.sv
// fifo_pump_if: PipeOut (source) and PipeIn (destination) method bundles for fifo_pump
interface fifo_pump_if #(parameter int width = 32);
  logic             deq__ENA;
  logic             deq__RDY;
  logic [width-1:0] first;
  logic             first__RDY;
  modport master(output deq__ENA, input deq__RDY, first, first__RDY);
  modport slave(input deq__ENA, output deq__RDY, first, first__RDY);
endinterface

interface fifo_pump_dst_if #(parameter int width = 32);
  logic             enq__ENA;
  logic [width-1:0] enq_v;
  logic             enq__RDY;
  modport master(output enq__ENA, enq_v, input enq__RDY);
  modport slave(input enq__ENA, enq_v, output enq__RDY);
endinterface

// File: rtl/fifo_pump.sv
// fifo_pump: 2-entry skid buffer draining a PipeOut server into a PipeIn server; FIFO_PUMP_COUNT_EN adds xfer_count
module fifo_pump #(
  parameter int width = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                run,
  fifo_pump_if.master         src,
  fifo_pump_dst_if.master     dst,
  output logic [1:0]          count,
  output logic                busy
`ifdef FIFO_PUMP_COUNT_EN
  ,
  output logic [31:0]         xfer_count
`endif
);
  logic [width-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             pull, push;
  assign pull = nRST && run && src.deq__RDY && src.first__RDY && (count_q != 2'd2);
  assign push = (count_q != 2'd0) && dst.enq__RDY;
  assign src.deq__ENA = pull;
  assign dst.enq__ENA = push;
  assign dst.enq_v    = (count_q != 2'd0) ? head_q : '0;
  assign count        = count_q;
  assign busy         = count_q != 2'd0;
  always_comb begin
    count_d = count_q + {1'b0, pull} - {1'b0, push};
    head_d  = (pull && (count_q == 2'd0 || push)) ? src.first : (push ? tail_q : head_q);
    tail_d  = (pull && !push && count_q == 2'd1) ? src.first : tail_q;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
`ifdef FIFO_PUMP_COUNT_EN
  logic [31:0] xfer_q;
  assign xfer_count = xfer_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) xfer_q <= '0;
    else if (push) xfer_q <= xfer_q + 32'd1;
  end
`endif
endmodule

// File: tb/tb_fifo_pump.sv
// tb_fifo_pump: directed self-checking bench for fifo_pump
module tb_fifo_pump;
  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       run = 1'b0;
  logic [1:0] count;
  logic       busy;
  int         checks = 0;
  int         failures = 0;
`ifdef FIFO_PUMP_COUNT_EN
  logic [31:0] xfer_count;
`endif
  fifo_pump_if #(.width(32))     src_if ();
  fifo_pump_dst_if #(.width(32)) dst_if ();
  fifo_pump #(.width(32)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .run(run),
    .src(src_if.master),
    .dst(dst_if.master),
    .count(count),
    .busy(busy)
`ifdef FIFO_PUMP_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic offer(input logic rdy, input logic [31:0] v);
    src_if.deq__RDY   = rdy;
    src_if.first__RDY = rdy;
    src_if.first      = v;
  endtask
  initial begin
    offer(1'b1, 32'h0);
    dst_if.enq__RDY = 1'b1;
    run = 1'b1;
    #12;
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_deq", {31'd0, src_if.deq__ENA}, 32'd0);
    chk("rst_enq", {31'd0, dst_if.enq__ENA}, 32'd0);
    nRST = 1'b1;
    offer(1'b1, 32'h11); #1;
    chk("b_deq0", {31'd0, src_if.deq__ENA}, 32'd1);
    chk("b_enq0", {31'd0, dst_if.enq__ENA}, 32'd0);
    tick(); offer(1'b1, 32'h22); #1;
    chk("b_v11", dst_if.enq_v, 32'h11);
    chk("b_enq1", {31'd0, dst_if.enq__ENA}, 32'd1);
    chk("b_deq1", {31'd0, src_if.deq__ENA}, 32'd1);
    tick(); offer(1'b1, 32'h33); #1;
    chk("b_v22", dst_if.enq_v, 32'h22);
    chk("b_cnt1", {30'd0, count}, 32'd1);
    tick(); offer(1'b0, 32'h0); #1;
    chk("b_v33", dst_if.enq_v, 32'h33);
    chk("b_deq_off", {31'd0, src_if.deq__ENA}, 32'd0);
    tick(); #1;
    chk("b_empty_enq", {31'd0, dst_if.enq__ENA}, 32'd0);
    chk("b_empty_v", dst_if.enq_v, 32'h0);
    chk("b_empty_busy", {31'd0, busy}, 32'd0);
    dst_if.enq__RDY = 1'b0;
    offer(1'b1, 32'hA0);
    tick(); offer(1'b1, 32'hA1);
    tick(); offer(1'b1, 32'hA2); #1;
    chk("bp_cnt2", {30'd0, count}, 32'd2);
    chk("bp_deq_full", {31'd0, src_if.deq__ENA}, 32'd0);
    chk("bp_enq_off", {31'd0, dst_if.enq__ENA}, 32'd0);
    tick(); #1;
    chk("bp_hold_cnt", {30'd0, count}, 32'd2);
    chk("bp_hold_v", dst_if.enq_v, 32'hA0);
    dst_if.enq__RDY = 1'b1; #1;
    chk("bp_enq_on", {31'd0, dst_if.enq__ENA}, 32'd1);
    chk("bp_deq_still", {31'd0, src_if.deq__ENA}, 32'd0);
    tick(); #1;
    chk("bp_vA1", dst_if.enq_v, 32'hA1);
    chk("bp_deq_again", {31'd0, src_if.deq__ENA}, 32'd1);
    tick(); offer(1'b0, 32'h0); #1;
    chk("bp_vA2", dst_if.enq_v, 32'hA2);
    chk("bp_cntA2", {30'd0, count}, 32'd1);
    tick(); #1;
    chk("bp_drained", {30'd0, count}, 32'd0);
    offer(1'b1, 32'h1000);
    tick();
    for (int i = 0; i < 100; i++) begin
      offer(1'b1, 32'h1001 + i); #1;
      chk("ss_cnt", {30'd0, count}, 32'd1);
      chk("ss_v", dst_if.enq_v, 32'h1000 + i);
      chk("ss_both", {30'd0, src_if.deq__ENA, dst_if.enq__ENA}, 32'd3);
      tick();
    end
    offer(1'b0, 32'h0); #1;
    chk("ss_last", dst_if.enq_v, 32'h1064);
    tick(); #1;
    chk("ss_empty", {30'd0, count}, 32'd0);
    dst_if.enq__RDY = 1'b0;
    offer(1'b1, 32'hB0);
    tick(); offer(1'b1, 32'hB1);
    tick(); offer(1'b1, 32'hB2);
    run = 1'b0;
    dst_if.enq__RDY = 1'b1; #1;
    chk("rg_cnt2", {30'd0, count}, 32'd2);
    chk("rg_deq0", {31'd0, src_if.deq__ENA}, 32'd0);
    chk("rg_vB0", dst_if.enq_v, 32'hB0);
    tick(); #1;
    chk("rg_vB1", dst_if.enq_v, 32'hB1);
    chk("rg_deq1", {31'd0, src_if.deq__ENA}, 32'd0);
    chk("rg_busy1", {31'd0, busy}, 32'd1);
    tick(); #1;
    chk("rg_busy0", {31'd0, busy}, 32'd0);
    run = 1'b1;
    dst_if.enq__RDY = 1'b0;
    offer(1'b1, 32'hC0);
    tick(); offer(1'b1, 32'hC1);
    tick(); offer(1'b1, 32'hC2); #1;
    chk("ar_full", {30'd0, count}, 32'd2);
    dst_if.enq__RDY = 1'b1;
    #2 nRST = 1'b0; #1;
    chk("ar_cnt", {30'd0, count}, 32'd0);
    chk("ar_deq", {31'd0, src_if.deq__ENA}, 32'd0);
    chk("ar_enq", {31'd0, dst_if.enq__ENA}, 32'd0);
    tick();
    nRST = 1'b1; #1;
    chk("ar_rel_enq", {31'd0, dst_if.enq__ENA}, 32'd0);
    tick(); offer(1'b0, 32'h0); #1;
    chk("ar_first_v", dst_if.enq_v, 32'hC2);
    chk("ar_first_enq", {31'd0, dst_if.enq__ENA}, 32'd1);
    tick(); #1;
`ifdef FIFO_PUMP_COUNT_EN
    force dut.xfer_q = 32'hFFFF_FFFE;
    #1 release dut.xfer_q;
    offer(1'b1, 32'hD0);
    tick(); offer(1'b1, 32'hD1);
    tick(); #1;
    chk("xc_ff", xfer_count, 32'hFFFF_FFFF);
    offer(1'b1, 32'hD2);
    tick(); offer(1'b0, 32'h0); #1;
    chk("xc_0", xfer_count, 32'h0);
    tick(); #1;
    chk("xc_1", xfer_count, 32'h1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_pump.md
FIFO_PUMP -- requirements
Module: fifo_pump

Interface
REQ-001 The parameter list SHALL be: width, 32, data bits per element.
REQ-002 The ports SHALL be, clock and reset first: CLK  input  1  sole clock, rising edge; nRST  input  1  reset, asynchronous, active-low.
REQ-003 The ports SHALL continue: run  input  1  enables pulling from the source; when low, no new element is taken.
REQ-004 Source side, PipeOut.client src: src.deq__ENA out 1; src.deq__RDY in 1; src.first in width; src.first__RDY in 1.
REQ-005 Destination side, PipeIn.client dst: dst.enq__ENA out 1; dst.enq$v out width; dst.enq__RDY in 1.
REQ-006 Status ports: count  output  2  number of buffered elements, 0..2; busy  output  1  high when count != 0.

Function
REQ-007 The block SHALL be a 2-entry skid buffer that drains a PipeOut server into a PipeIn server (head and tail registers).
REQ-008 Pull condition: src.deq__ENA = run && src.deq__RDY && src.first__RDY && (count != 2).
REQ-009 src.deq__ENA SHALL have no combinational dependence on dst.enq__RDY; depending only on registered count is what keeps that path open.
REQ-010 Push condition: dst.enq__ENA = (count != 0) && dst.enq__RDY.
REQ-011 dst.enq$v SHALL equal the head entry, and 0 when count == 0.
REQ-012 An element taken on cycle N SHALL be presented on dst.enq$v in cycle N+1; minimum latency 1 cycle, with no combinational bypass.
REQ-013 Pull only: count SHALL increment, and src.first SHALL be written to the head if count == 0, otherwise to the tail.
REQ-014 Push only: count SHALL decrement, and the tail SHALL move to the head.
REQ-015 Pull and push in the same cycle: count SHALL be unchanged.
REQ-016 Same-cycle pull and push with count == 1: the head SHALL load src.first.
REQ-017 Same-cycle pull and push with count == 2: cannot happen, because REQ-008 forbids the pull.
REQ-018 With a continuous source and sink, throughput SHALL be 1 element per cycle.
REQ-019 Full (count == 2): src.deq__ENA SHALL be low; contents held until dst.enq__RDY.
REQ-020 Empty (count == 0): dst.enq__ENA SHALL be low.
REQ-021 When run is deasserted, buffered elements SHALL still drain to dst.
REQ-022 Order SHALL be strictly FIFO; no element is dropped or duplicated.

Reset
REQ-023 Asserting nRST low SHALL asynchronously clear the head, the tail and count to 0, and the transfer counter to 0 if configured.
REQ-024 During reset, src.deq__ENA and dst.enq__ENA SHALL be 0.
REQ-025 Reset mid-operation SHALL discard buffered elements; no enq issues in the first cycle after release.
REQ-026 Reset release SHALL be used synchronously to CLK.

Configuration
REQ-027 When FIFO_PUMP_COUNT_EN is defined, an output xfer_count (32 bits) SHALL be present.
REQ-028 xfer_count SHALL increment on every cycle with dst.enq__ENA high and wrap from 0xFFFFFFFF to 0.
REQ-029 Without FIFO_PUMP_COUNT_EN, the xfer_count port and its register SHALL be absent, with identical data-path behaviour.

Verification
REQ-030 Basic: reset, run=1, source offers 0x11, 0x22, 0x33, sink always ready -> dst sees 0x11, 0x22, 0x33 on consecutive cycles, each 1 cycle after its deq.
REQ-031 Backpressure: sink not ready, source offers 0xA0, 0xA1, 0xA2 -> count reaches 2, src.deq__ENA low with 0xA2 pending; sink ready -> 0xA0, 0xA1, 0xA2 delivered in order.
REQ-032 Steady state: count == 1 with simultaneous pull and push for 100 cycles -> count stays 1, 100 in-order transfers.
REQ-033 Run gating: run=0 with count=2 and sink ready -> both entries drained, no src.deq__ENA, busy falls after 2 cycles.
REQ-034 Async reset: assert nRST mid-cycle with count=2 -> count=0 and enq/deq low immediately; after release, first enq carries the next source value.
REQ-035 Counter: with FIFO_PUMP_COUNT_EN, preload xfer_count 0xFFFFFFFE by forcing, then 3 transfers -> 0xFFFFFFFF, 0, 1.
